// File: rtl/cache_line_controller_if.sv
// Processor-side and memory-side handshake bundle of the direct-mapped line controller.
// The controller takes the slave view; the surrounding CPU/memory environment takes the master view.
interface cache_line_controller_if #(
  parameter int unsigned ADDR_SIZE = 16,
  parameter int unsigned LINE_SIZE = 128
);
  localparam int unsigned WORD_SIZE = 16;

  // processor side
  logic                 CPU_RD;
  logic                 CPU_WR;
  logic [ADDR_SIZE-1:0] CPU_ADDR;
  logic [WORD_SIZE-1:0] CPU_WDATA;
  logic [WORD_SIZE-1:0] CPU_RDATA;
  logic                 CPU_ACK;

  // memory interface side
  logic                 MEM_RD;
  logic                 MEM_WR;
  logic [ADDR_SIZE-1:0] MEM_ADDR;
  logic [LINE_SIZE-1:0] MEM_WDATA;
  logic [LINE_SIZE-1:0] MEM_RDATA;
  logic                 MEM_ACK;

  modport master (
    output CPU_RD, CPU_WR, CPU_ADDR, CPU_WDATA, MEM_RDATA, MEM_ACK,
    input  CPU_RDATA, CPU_ACK, MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA
  );

  modport slave (
    input  CPU_RD, CPU_WR, CPU_ADDR, CPU_WDATA, MEM_RDATA, MEM_ACK,
    output CPU_RDATA, CPU_ACK, MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/cache_line_controller.sv
// Direct-mapped, write-through, write-allocate cache controller: serves 16-bit CPU words
// from a small line store, issuing whole-line fills and whole-line write-throughs.
module cache_line_controller #(
  parameter int unsigned ADDR_SIZE   = 16,
  parameter int unsigned OFFSET_SIZE = 4,
  parameter int unsigned LINE_SIZE   = 128,
  parameter int unsigned INDEX_SIZE  = 2
) (
  input  logic                      CACHE_CLK,
  input  logic                      CACHE_RESET,
  cache_line_controller_if.slave    bus,
  output logic [15:0]               HIT_COUNT,
  output logic [15:0]               MISS_COUNT
);

  localparam int unsigned WORD_SIZE     = 16;
  localparam int unsigned TAG_SIZE      = ADDR_SIZE - OFFSET_SIZE - INDEX_SIZE;
  localparam int unsigned LINES         = 1 << INDEX_SIZE;
  localparam int unsigned WORD_SEL_SIZE = OFFSET_SIZE - 1;
  localparam int unsigned LINE_BIT_SIZE = $clog2(LINE_SIZE);
  localparam logic [15:0] CNT_MAX       = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WTHRU = 2'd2
  } state_t;

  state_t                 state_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_SIZE-1:0]    tag_q  [LINES];
  logic [LINE_SIZE-1:0]   data_q [LINES];

  logic                   filled_q;
  logic                   cpu_ack_q;
  logic [WORD_SIZE-1:0]   cpu_rdata_q;
  logic                   mem_rd_q;
  logic                   mem_wr_q;
  logic [ADDR_SIZE-1:0]   mem_addr_q;
  logic [LINE_SIZE-1:0]   mem_wdata_q;
  logic [15:0]            hit_count_q;
  logic [15:0]            miss_count_q;

  logic [TAG_SIZE-1:0]      req_tag_c;
  logic [INDEX_SIZE-1:0]    req_idx_c;
  logic [WORD_SEL_SIZE-1:0] word_sel_c;
  logic [LINE_BIT_SIZE-1:0] word_base_c;
  logic [ADDR_SIZE-1:0]     line_addr_c;
  logic                     hit_c;
  logic                     req_c;
  logic [WORD_SIZE-1:0]     rd_word_c;
  logic [LINE_SIZE-1:0]     merged_c;
  logic [INDEX_SIZE-1:0]    fill_idx_c;
  logic [TAG_SIZE-1:0]      fill_tag_c;
  logic                     unused_addr_bit;

  // Byte-lane bit 0 carries no information for word accesses.
  assign unused_addr_bit = bus.CPU_ADDR[0];

  // Address decode, lookup and write merge for the request currently presented.
  always_comb begin
    req_tag_c   = bus.CPU_ADDR[ADDR_SIZE-1 -: TAG_SIZE];
    req_idx_c   = bus.CPU_ADDR[OFFSET_SIZE +: INDEX_SIZE];
    word_sel_c  = bus.CPU_ADDR[1 +: WORD_SEL_SIZE];
    word_base_c = LINE_BIT_SIZE'({word_sel_c, 4'b0000});
    line_addr_c = {req_tag_c, req_idx_c, {OFFSET_SIZE{1'b0}}};
    hit_c       = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);
    req_c       = bus.CPU_RD || bus.CPU_WR;
    rd_word_c   = data_q[req_idx_c][word_base_c +: WORD_SIZE];
    merged_c    = data_q[req_idx_c];
    merged_c[word_base_c +: WORD_SIZE] = bus.CPU_WDATA;
    // Fills are installed from the registered request address, not the live CPU bus.
    fill_idx_c  = mem_addr_q[OFFSET_SIZE +: INDEX_SIZE];
    fill_tag_c  = mem_addr_q[ADDR_SIZE-1 -: TAG_SIZE];
  end

  // Controller FSM, line store and counters.
  always_ff @(posedge CACHE_CLK or negedge CACHE_RESET) begin
    if (!CACHE_RESET) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      for (int i = 0; i < int'(LINES); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      filled_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The cycle carrying CPU_ACK still sees the old request held; skip it.
          if (!cpu_ack_q && req_c) begin
            if (!hit_c) begin
              mem_addr_q <= line_addr_c;
              mem_rd_q   <= 1'b1;
              filled_q   <= 1'b1;
              if (miss_count_q != CNT_MAX) miss_count_q <= miss_count_q + 16'd1;
              state_q    <= S_FILL;
            end else if (bus.CPU_RD) begin
              cpu_rdata_q <= rd_word_c;
              cpu_ack_q   <= 1'b1;
              filled_q    <= 1'b0;
              if (!filled_q && hit_count_q != CNT_MAX) hit_count_q <= hit_count_q + 16'd1;
            end else begin
              data_q[req_idx_c] <= merged_c;
              mem_wdata_q       <= merged_c;
              mem_addr_q        <= line_addr_c;
              mem_wr_q          <= 1'b1;
              if (!filled_q && hit_count_q != CNT_MAX) hit_count_q <= hit_count_q + 16'd1;
              state_q           <= S_WTHRU;
            end
          end
        end
        S_FILL: begin
          if (bus.MEM_ACK) begin
            data_q[fill_idx_c]  <= bus.MEM_RDATA;
            tag_q[fill_idx_c]   <= fill_tag_c;
            valid_q[fill_idx_c] <= 1'b1;
            mem_rd_q            <= 1'b0;
            state_q             <= S_IDLE;
          end
        end
        S_WTHRU: begin
          if (bus.MEM_ACK) begin
            mem_wr_q  <= 1'b0;
            cpu_ack_q <= 1'b1;
            filled_q  <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.CPU_ACK   = cpu_ack_q;
  assign bus.CPU_RDATA = cpu_rdata_q;
  assign bus.MEM_RD    = mem_rd_q;
  assign bus.MEM_WR    = mem_wr_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WDATA = mem_wdata_q;
  assign HIT_COUNT     = hit_count_q;
  assign MISS_COUNT    = miss_count_q;

endmodule

// File: tb/tb_cache_line_controller.sv
// Bench for cache_line_controller: directed scenarios plus random traffic, checked against
// a behavioural direct-mapped cache model and a line-granular memory responder.
module tb_cache_line_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  cache_line_controller_if bus ();

  cache_line_controller dut (
    .CACHE_CLK  (clk),
    .CACHE_RESET(rst_n),
    .bus        (bus),
    .HIT_COUNT  (hit_count),
    .MISS_COUNT (miss_count)
  );

  int errors = 0;
  int checks = 0;

  // memory responder state and observed bus events
  logic [127:0] mem [int];
  int           mem_lat = 3;
  int           cyc = 0;
  int           rd_reqs = 0, wr_reqs = 0, acks = 0, both_high = 0;
  int           mem_ack_cyc = 0, cpu_ack_cyc = 0;
  logic [15:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  // reference model state
  bit           m_valid [4];
  int           m_tag   [4];
  int           m_hit = 0, m_miss = 0;
  logic [127:0] exp_mem [int];
  logic [15:0]  last_got;

  function automatic logic [127:0] line_init(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = 16'hA000 + 16'(k) + (a ^ 16'h0120);
    return l;
  endfunction

  function automatic logic [127:0] mem_get(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : line_init(a);
  endfunction

  function automatic logic [127:0] exp_get(input logic [15:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : line_init(a);
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end
    m_hit  = 0;
    m_miss = 0;
  endtask

  // Memory interface responder: answers each line request after mem_lat cycles with a one-cycle ACK.
  initial begin
    int  cnt;
    logic prev_rd, prev_wr;
    cnt = 0; prev_rd = 1'b0; prev_wr = 1'b0;
    bus.MEM_ACK   = 1'b0;
    bus.MEM_RDATA = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        bus.MEM_ACK = 1'b0;
        cnt = 0; prev_rd = 1'b0; prev_wr = 1'b0;
      end else begin
        if (bus.MEM_RD && !prev_rd) begin rd_reqs++; last_rd_addr = bus.MEM_ADDR; end
        if (bus.MEM_WR && !prev_wr) begin wr_reqs++; last_wr_addr = bus.MEM_ADDR; last_wr_data = bus.MEM_WDATA; end
        if (bus.MEM_RD && bus.MEM_WR) both_high++;
        if (bus.CPU_ACK) begin acks++; cpu_ack_cyc = cyc; end
        prev_rd = bus.MEM_RD;
        prev_wr = bus.MEM_WR;
        if (bus.MEM_ACK) begin
          bus.MEM_ACK = 1'b0;
        end else if (bus.MEM_RD || bus.MEM_WR) begin
          cnt++;
          if (cnt >= mem_lat) begin
            cnt = 0;
            if (bus.MEM_WR) mem[int'(bus.MEM_ADDR)] = bus.MEM_WDATA;
            else            bus.MEM_RDATA = mem_get(bus.MEM_ADDR);
            bus.MEM_ACK = 1'b1;
            mem_ack_cyc = cyc;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // One CPU transaction, predicted by the model then checked on every observable effect.
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input string name);
    logic [15:0]  line;
    logic [15:0]  exp_rdata;
    logic [127:0] l;
    int idx, tg, k, r0, w0, a0, n;
    bit miss, is_rd, seen;
    line  = addr & 16'hFFF0;
    idx   = int'(addr[5:4]);
    tg    = int'(addr[15:6]);
    k     = int'(addr[3:1]);
    is_rd = rd;
    miss  = !(m_valid[idx] && m_tag[idx] == tg);
    if (miss) begin
      m_miss = sat(m_miss);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end else begin
      m_hit = sat(m_hit);
    end
    l = exp_get(line);
    exp_rdata = l[16*k +: 16];
    if (!is_rd) begin
      l[16*k +: 16] = wdata;
      exp_mem[int'(line)] = l;
    end
    r0 = rd_reqs; w0 = wr_reqs; a0 = acks;

    @(posedge clk); #2;
    bus.CPU_RD = rd; bus.CPU_WR = wr; bus.CPU_ADDR = addr; bus.CPU_WDATA = wdata;
    n = 0; seen = 1'b0; last_got = '0;
    while (n < 400 && !seen) begin
      @(posedge clk); #2;
      n++;
      if (bus.CPU_ACK) begin seen = 1'b1; last_got = bus.CPU_RDATA; end
    end
    @(posedge clk); #2;
    bus.CPU_RD = 1'b0; bus.CPU_WR = 1'b0;
    @(posedge clk); #2;

    check({name, ".ack_seen"}, 128'(seen), 128'(1));
    if (is_rd) check({name, ".rdata"}, 128'(last_got), 128'(exp_rdata));
    if (is_rd && !miss) check({name, ".hit_latency"}, 128'(n), 128'(1));
    if (is_rd && miss)  check({name, ".fill_to_ack"}, 128'(cpu_ack_cyc - mem_ack_cyc), 128'(2));
    if (!is_rd)         check({name, ".wthru_to_ack"}, 128'(cpu_ack_cyc - mem_ack_cyc), 128'(1));
    check({name, ".hit_count"}, 128'(hit_count), 128'(m_hit));
    check({name, ".miss_count"}, 128'(miss_count), 128'(m_miss));
    check({name, ".fills"}, 128'(rd_reqs - r0), 128'(miss ? 1 : 0));
    if (miss) check({name, ".fill_addr"}, 128'(last_rd_addr), 128'(line));
    check({name, ".wthrus"}, 128'(wr_reqs - w0), 128'(is_rd ? 0 : 1));
    if (!is_rd) begin
      check({name, ".wthru_addr"}, 128'(last_wr_addr), 128'(line));
      check({name, ".wthru_data"}, last_wr_data, l);
    end
    check({name, ".ack_pulses"}, 128'(acks - a0), 128'(1));
  endtask

  initial begin
    logic [127:0] wline;
    logic [15:0]  a;
    rst_n = 1'b1;
    bus.CPU_RD = 1'b0; bus.CPU_WR = 1'b0; bus.CPU_ADDR = '0; bus.CPU_WDATA = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst.cpu_ack", 128'(bus.CPU_ACK), 128'(0));
    check("rst.cpu_rdata", 128'(bus.CPU_RDATA), 128'(0));
    check("rst.mem_rd", 128'(bus.MEM_RD), 128'(0));
    check("rst.mem_wr", 128'(bus.MEM_WR), 128'(0));
    check("rst.mem_addr", 128'(bus.MEM_ADDR), 128'(0));
    check("rst.mem_wdata", bus.MEM_WDATA, 128'(0));
    check("rst.counts", 128'({hit_count, miss_count}), 128'(0));
    @(negedge clk) rst_n = 1'b1;

    // cold read, then hit in the same line
    mem_lat = 20;
    do_txn(1'b1, 1'b0, 16'h0124, 16'h0, "s1_cold");
    check("s1.fill_addr", 128'(last_rd_addr), 128'(16'h0120));
    check("s1.rdata", 128'(last_got), 128'(16'hA002));
    check("s1.miss", 128'(miss_count), 128'(1));
    do_txn(1'b1, 1'b0, 16'h012E, 16'h0, "s1_hit");
    check("s1.hit_rdata", 128'(last_got), 128'(16'hA007));
    check("s1.hit", 128'(hit_count), 128'(1));

    // write hit and read-back
    mem_lat = 4;
    do_txn(1'b0, 1'b1, 16'h0126, 16'hBEEF, "s2_wr");
    wline = last_wr_data;
    check("s2.word3", 128'(wline[63:48]), 128'(16'hBEEF));
    check("s2.word0", 128'(wline[15:0]), 128'(16'hA000));
    do_txn(1'b1, 1'b0, 16'h0126, 16'h0, "s2_rd");
    check("s2.readback", 128'(last_got), 128'(16'hBEEF));

    // index-2 conflict ping-pong (evict first so all three miss)
    do_txn(1'b1, 1'b0, 16'h3124, 16'h0, "s3_evict");
    do_txn(1'b1, 1'b0, 16'h0124, 16'h0, "s3_a");
    do_txn(1'b1, 1'b0, 16'h1124, 16'h0, "s3_b");
    do_txn(1'b1, 1'b0, 16'h0124, 16'h0, "s3_c");
    check("s3.reload_addr", 128'(last_rd_addr), 128'(16'h0120));

    // write miss: fill then write-through
    do_txn(1'b0, 1'b1, 16'h2032, 16'h1234, "s4_wmiss");
    wline = last_wr_data;
    check("s4.fill_addr", 128'(last_rd_addr), 128'(16'h2030));
    check("s4.wr_addr", 128'(last_wr_addr), 128'(16'h2030));
    check("s4.word1", 128'(wline[31:16]), 128'(16'h1234));

    // simultaneous read and write is a read
    do_txn(1'b1, 1'b1, 16'h0124, 16'h5555, "s6_both");

    // random traffic over a few conflicting tags
    for (int i = 0; i < 40; i++) begin
      logic [9:0] tags [4];
      tags[0] = 10'h004; tags[1] = 10'h044; tags[2] = 10'h080; tags[3] = 10'h3FF;
      mem_lat = int'($urandom_range(1, 5));
      a = {tags[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 1) == 0) do_txn(1'b1, 1'b0, a, 16'h0, "rnd_rd");
      else                           do_txn(1'b0, 1'b1, a, 16'($urandom), "rnd_wr");
    end

    // reset in the middle of a fill
    do_txn(1'b1, 1'b0, 16'h0124, 16'h0, "s5_prime");
    mem_lat = 20;
    @(posedge clk); #2;
    bus.CPU_RD = 1'b1; bus.CPU_ADDR = 16'h1124;
    repeat (5) @(posedge clk);
    #2;
    check("s5.fill_pending", 128'(bus.MEM_RD), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    check("s5.mem_rd_drop", 128'(bus.MEM_RD), 128'(0));
    check("s5.cpu_ack_low", 128'(bus.CPU_ACK), 128'(0));
    check("s5.counts_clear", 128'({hit_count, miss_count}), 128'(0));
    bus.CPU_RD = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    do_txn(1'b1, 1'b0, 16'h0124, 16'h0, "s5_after");
    check("s5.remiss", 128'(miss_count), 128'(1));

    check("never_rd_and_wr", 128'(both_high), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
